// File: rtl/wb_pwm_pkg.sv
// Shared constants for the Wishbone PWM block: address decode, register offsets, CTRL bits.
// Also holds the byte-lane merge helper used by every writable register.
package wb_pwm_pkg;

  localparam int ADR_LSB = 2;
  localparam int ADR_MSB = 9;
  localparam int CH_STRIDE_LOG2 = 2;  // four word registers per channel block

  localparam logic [7:0] W_GCTRL = 8'h00;
  localparam logic [7:0] W_GSTAT = 8'h01;

  localparam logic [1:0] R_CTRL   = 2'd0;
  localparam logic [1:0] R_PERIOD = 2'd1;
  localparam logic [1:0] R_DUTY   = 2'd2;
  localparam logic [1:0] R_CNT    = 2'd3;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_POL    = 1;
  localparam int CTRL_CENTER = 2;
  localparam int CTRL_W      = 3;

  typedef enum logic {BUS_IDLE, BUS_ACK} bus_state_e;
  typedef enum logic {DIR_UP, DIR_DOWN} dir_e;

  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{sel[b]}};
    return m;
  endfunction

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  sel);
    return (old_v & ~lane_mask(sel)) | (new_v & lane_mask(sel));
  endfunction

endpackage

// File: rtl/wb_pwm_gen_if.sv
// Wishbone classic slave bundle for the PWM block; master drives requests, slave returns data/ack.
interface wb_pwm_gen_if;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_we_i;
  logic [31:0] wb_adr_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;

  modport master (output wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
                  input  wb_dat_o, wb_ack_o);
  modport slave  (input  wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
                  output wb_dat_o, wb_ack_o);
endinterface

// File: rtl/wb_pwm_gen_channel.sv
// One PWM channel: edge/center counter, shadow period/duty reloaded at wrap, polarity.
// Output is registered one clock behind the counter; advances only on prescaler tick.
module pwm_channel
  import wb_pwm_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tick_i,
  input  logic             en_i,
  input  logic             pol_i,
  input  logic             center_i,
  input  logic [CNT_W-1:0] period_i,
  input  logic [CNT_W-1:0] duty_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             pwm_o,
  output logic             wrap_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] sh_period_q, sh_period_d;
  logic [CNT_W-1:0] sh_duty_q, sh_duty_d;
  dir_e             dir_q, dir_d;
  logic             pwm_q, pwm_d;
  logic             wrap;

  always_comb begin
    cnt_d       = cnt_q;
    dir_d       = dir_q;
    sh_period_d = sh_period_q;
    sh_duty_d   = sh_duty_q;
    wrap        = 1'b0;
    pwm_d       = en_i ? ((cnt_q < sh_duty_q) ^ pol_i) : pol_i;

    if (!en_i) begin
      cnt_d       = '0;
      dir_d       = DIR_UP;
      sh_period_d = period_i;
      sh_duty_d   = duty_i;
    end else begin
      // Holding dir at UP outside center mode makes a later switch start counting up.
      if (!center_i) dir_d = DIR_UP;
      if (tick_i) begin
        if (!center_i || dir_q == DIR_UP) begin
          if (cnt_q >= sh_period_q) begin
            if (center_i && sh_period_q != '0) begin
              cnt_d = cnt_q - CNT_W'(1);
              dir_d = DIR_DOWN;
            end else begin
              cnt_d = '0;
              wrap  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (cnt_q <= CNT_W'(1)) begin
          cnt_d = '0;
          dir_d = DIR_UP;
          wrap  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
        if (wrap) begin
          sh_period_d = period_i;
          sh_duty_d   = duty_i;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q       <= '0;
      dir_q       <= DIR_UP;
      sh_period_q <= '0;
      sh_duty_q   <= '0;
      pwm_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      dir_q       <= dir_d;
      sh_period_q <= sh_period_d;
      sh_duty_q   <= sh_duty_d;
      pwm_q       <= pwm_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign pwm_o  = pwm_q;
  assign wrap_o = wrap;

endmodule

// File: rtl/wb_pwm_gen.sv
// Wishbone PWM peripheral: bus FSM, register file, shared prescaler, wrap status, NUM_CH channels.
// Every bus access takes two clocks (one wait state); the bus never stalls beyond that.
module wb_pwm_gen
  import wb_pwm_pkg::*;
#(
  parameter int NUM_CH  = 8,
  parameter int CNT_W   = 16,
  parameter int PRESC_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  wb_pwm_gen_if.slave       wb,
  output logic [NUM_CH-1:0] pwmo
);

  bus_state_e state_q, state_d;
  logic       wr_en, rd_en;
  logic [31:0] dat_q, dat_d, rd_val;

  logic [7:0] word_idx;
  logic [5:0] blk;
  logic [1:0] sub;

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
  logic               tick;

  logic [NUM_CH-1:0]             gstat_q, gstat_d;
  logic [NUM_CH-1:0]             wrap;
  logic [NUM_CH-1:0][CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [NUM_CH-1:0][CNT_W-1:0]  period_q, period_d;
  logic [NUM_CH-1:0][CNT_W-1:0]  duty_q, duty_d;
  logic [NUM_CH-1:0][CNT_W-1:0]  cnt_w;

  logic [31:0] wr_old, wr_new, gstat_clr;
  logic        unused_bits;

  assign word_idx = wb.wb_adr_i[ADR_MSB:ADR_LSB];
  assign blk      = word_idx[7:CH_STRIDE_LOG2];
  assign sub      = word_idx[1:0];

  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    case (state_q)
      BUS_IDLE: begin
        if (wb.wb_stb_i && wb.wb_cyc_i) begin
          state_d = BUS_ACK;
          wr_en   = wb.wb_we_i;
          rd_en   = !wb.wb_we_i;
        end
      end
      BUS_ACK: state_d = BUS_IDLE;
      default: state_d = BUS_IDLE;
    endcase
    dat_d = rd_en ? rd_val : dat_q;
  end

  // Channel blocks start at word 4; block 0 holds the global registers.
  always_comb begin
    rd_val = '0;
    if (word_idx == W_GCTRL) begin
      rd_val[PRESC_W-1:0] = presc_q;
    end else if (word_idx == W_GSTAT) begin
      rd_val[NUM_CH-1:0] = gstat_q;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (blk == 6'(i + 1)) begin
          case (sub)
            R_CTRL:   rd_val[CTRL_W-1:0] = ctrl_q[i];
            R_PERIOD: rd_val[CNT_W-1:0]  = period_q[i];
            R_DUTY:   rd_val[CNT_W-1:0]  = duty_q[i];
            default:  rd_val[CNT_W-1:0]  = cnt_w[i];
          endcase
        end
      end
    end
  end

  always_comb begin
    presc_d   = presc_q;
    ctrl_d    = ctrl_q;
    period_d  = period_q;
    duty_d    = duty_q;
    gstat_clr = '0;
    wr_old    = '0;
    wr_new    = '0;
    if (wr_en) begin
      if (word_idx == W_GCTRL) begin
        wr_old[PRESC_W-1:0] = presc_q;
        wr_new  = merge_lanes(wr_old, wb.wb_dat_i, wb.wb_sel_i);
        presc_d = wr_new[PRESC_W-1:0];
      end else if (word_idx == W_GSTAT) begin
        gstat_clr = wb.wb_dat_i & lane_mask(wb.wb_sel_i);
      end else begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (blk == 6'(i + 1)) begin
            case (sub)
              R_CTRL: begin
                wr_old[CTRL_W-1:0] = ctrl_q[i];
                wr_new    = merge_lanes(wr_old, wb.wb_dat_i, wb.wb_sel_i);
                ctrl_d[i] = wr_new[CTRL_W-1:0];
              end
              R_PERIOD: begin
                wr_old[CNT_W-1:0] = period_q[i];
                wr_new      = merge_lanes(wr_old, wb.wb_dat_i, wb.wb_sel_i);
                period_d[i] = wr_new[CNT_W-1:0];
              end
              R_DUTY: begin
                wr_old[CNT_W-1:0] = duty_q[i];
                wr_new    = merge_lanes(wr_old, wb.wb_dat_i, wb.wb_sel_i);
                duty_d[i] = wr_new[CNT_W-1:0];
              end
              default: ;
            endcase
          end
        end
      end
    end
  end

  assign tick        = (presc_cnt_q >= presc_q);
  assign presc_cnt_d = tick ? '0 : presc_cnt_q + PRESC_W'(1);
  // A wrap on the same edge as a W1C clear keeps the flag set.
  assign gstat_d     = (gstat_q & ~gstat_clr[NUM_CH-1:0]) | wrap;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= BUS_IDLE;
      dat_q       <= '0;
      presc_q     <= '0;
      presc_cnt_q <= '0;
      gstat_q     <= '0;
      ctrl_q      <= '0;
      period_q    <= '0;
      duty_q      <= '0;
    end else begin
      state_q     <= state_d;
      dat_q       <= dat_d;
      presc_q     <= presc_d;
      presc_cnt_q <= presc_cnt_d;
      gstat_q     <= gstat_d;
      ctrl_q      <= ctrl_d;
      period_q    <= period_d;
      duty_q      <= duty_d;
    end
  end

  assign wb.wb_ack_o = wb.wb_stb_i & wb.wb_cyc_i & (state_q == BUS_ACK);
  assign wb.wb_dat_o = dat_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pwm_channel #(.CNT_W(CNT_W)) u_ch (
      .clk      (clk),
      .reset_n  (reset_n),
      .tick_i   (tick),
      .en_i     (ctrl_q[g][CTRL_EN]),
      .pol_i    (ctrl_q[g][CTRL_POL]),
      .center_i (ctrl_q[g][CTRL_CENTER]),
      .period_i (period_q[g]),
      .duty_i   (duty_q[g]),
      .cnt_o    (cnt_w[g]),
      .pwm_o    (pwmo[g]),
      .wrap_o   (wrap[g])
    );
  end

  assign unused_bits = ^{wb.wb_adr_i[31:ADR_MSB+1], wb.wb_adr_i[ADR_LSB-1:0], wr_new, gstat_clr};

endmodule

// File: tb/tb_wb_pwm_gen.sv
// Directed bench for wb_pwm_gen: reset, edge/center waveforms, shadow reload, boundaries, bus.
module tb_wb_pwm_gen;
  localparam int NUM_CH = 8;
  localparam int HMAX   = 8192;

  logic              clk;
  logic              reset_n;
  logic [NUM_CH-1:0] pwmo;
  wb_pwm_gen_if      bus ();

  int n_cmp = 0;
  int n_bad = 0;

  bit hist [HMAX];
  int hist_n = 0;

  wb_pwm_gen #(.NUM_CH(NUM_CH), .CNT_W(16), .PRESC_W(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .wb      (bus),
    .pwmo    (pwmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (hist_n < HMAX) hist[hist_n] = pwmo[0];
    hist_n = hist_n + 1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic int find_rise(int from);
    int res = -1;
    for (int k = (from < 1) ? 1 : from; k < hist_n && k < HMAX; k++)
      if (res < 0 && hist[k] && !hist[k-1]) res = k;
    return res;
  endfunction

  function automatic int run_len(int at, bit v);
    int k;
    if (at < 0) return -1;
    k = at;
    while (k < hist_n && k < HMAX && hist[k] == v) k++;
    return k - at;
  endfunction

  function automatic int count_hi(int from, int len);
    int c = 0;
    for (int k = from; k < from + len && k < HMAX; k++) if (hist[k]) c++;
    return c;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    int n = 0;
    @(posedge clk); #1;
    bus.wb_stb_i = 1'b1; bus.wb_cyc_i = 1'b1; bus.wb_we_i = 1'b1;
    bus.wb_adr_i = adr;  bus.wb_dat_i = dat;  bus.wb_sel_i = sel;
    do begin @(negedge clk); n++; end while (bus.wb_ack_o !== 1'b1 && n < 8);
    if (bus.wb_ack_o !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL wr_timeout adr=%h: no ack within %0d clocks", adr, n);
    end
    @(posedge clk); #1;
    bus.wb_stb_i = 1'b0; bus.wb_cyc_i = 1'b0; bus.wb_we_i = 1'b0;
  endtask

  task automatic wb_read(input logic [31:0] adr, output logic [31:0] dat, output int ncyc);
    @(posedge clk); #1;
    bus.wb_stb_i = 1'b1; bus.wb_cyc_i = 1'b1; bus.wb_we_i = 1'b0;
    bus.wb_adr_i = adr;  bus.wb_sel_i = 4'hF;
    ncyc = 0;
    dat  = '0;
    do begin @(negedge clk); ncyc++; end while (bus.wb_ack_o !== 1'b1 && ncyc < 8);
    if (bus.wb_ack_o !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL rd_timeout adr=%h: no ack within %0d clocks", adr, ncyc);
    end else begin
      dat = bus.wb_dat_o;
    end
    @(posedge clk); #1;
    bus.wb_stb_i = 1'b0; bus.wb_cyc_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    int          nc;
    logic [31:0] adrs [6];
    adrs = '{32'h00, 32'h04, 32'h10, 32'h14, 32'h18, 32'h1C};
    n_cmp++; if (pwmo !== '0) begin n_bad++; $display("FAIL por_pwmo got %h want 0", pwmo); end
    n_cmp++; if (bus.wb_dat_o !== 32'h0) begin n_bad++; $display("FAIL por_dat got %h want 0", bus.wb_dat_o); end
    @(negedge clk); reset_n = 1'b1;
    wb_write(32'h14, 32'd9, 4'hF);
    wb_write(32'h18, 32'd3, 4'hF);
    wb_write(32'h10, 32'h1, 4'hF);
    wait_clk(6);
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (pwmo !== '0) begin n_bad++; $display("FAIL rst_pwmo got %h want 0", pwmo); end
    n_cmp++; if (bus.wb_ack_o !== 1'b0) begin n_bad++; $display("FAIL rst_ack got %b want 0", bus.wb_ack_o); end
    n_cmp++; if (bus.wb_dat_o !== 32'h0) begin n_bad++; $display("FAIL rst_dat got %h want 0", bus.wb_dat_o); end
    @(negedge clk); @(negedge clk); reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++; if (bus.wb_ack_o !== 1'b0) begin n_bad++; $display("FAIL rst_idle_ack got %b want 0", bus.wb_ack_o); end
    end
    for (int k = 0; k < 6; k++) begin
      wb_read(adrs[k], rd, nc);
      n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL rst_reg_%h got %h want 0", adrs[k], rd); end
    end
    n_cmp++; if (pwmo !== '0) begin n_bad++; $display("FAIL rst_pwmo_after got %h want 0", pwmo); end
  endtask

  task automatic test_edge();
    int m, r1, r2;
    logic [31:0] rd;
    int nc;
    wb_write(32'h14, 32'd9, 4'hF);
    wb_write(32'h18, 32'd3, 4'hF);
    wb_write(32'h10, 32'h1, 4'hF);
    wait_clk(5);
    m = hist_n;
    wait_clk(30);
    r1 = find_rise(m);
    r2 = find_rise(r1 + 1);
    n_cmp++; if (run_len(r1, 1'b1) !== 3) begin n_bad++; $display("FAIL edge_high got %0d want 3", run_len(r1, 1'b1)); end
    n_cmp++; if (run_len(r1 + 3, 1'b0) !== 7) begin n_bad++; $display("FAIL edge_low got %0d want 7", run_len(r1 + 3, 1'b0)); end
    n_cmp++; if (r2 - r1 !== 10) begin n_bad++; $display("FAIL edge_period got %0d want 10", r2 - r1); end
    wb_write(32'h04, 32'h1, 4'hF);
    wait_clk(12);
    wb_read(32'h04, rd, nc);
    n_cmp++; if (rd !== 32'h1) begin n_bad++; $display("FAIL edge_gstat got %h want 1", rd); end
    wb_read(32'h1C, rd, nc);
    n_cmp++; if (rd > 32'd9) begin n_bad++; $display("FAIL edge_cnt_range got %0d want <=9", rd); end
  endtask

  task automatic test_duty_change();
    int r = -1;
    int r2;
    for (int k = 0; k < 40 && r < 0; k++) begin
      @(negedge clk); #1;
      if (hist_n >= 2 && hist[hist_n-1] && !hist[hist_n-2]) r = hist_n - 1;
    end
    n_cmp++;
    if (r < 0) begin
      n_bad++; $display("FAIL duty_sync got no rising edge want one within 40 clocks");
    end else begin
      wb_write(32'h18, 32'd7, 4'hF);
      wait_clk(30);
      r2 = find_rise(r + 1);
      n_cmp++; if (run_len(r, 1'b1) !== 3) begin n_bad++; $display("FAIL duty_cur_high got %0d want 3", run_len(r, 1'b1)); end
      n_cmp++; if (r2 - r !== 10) begin n_bad++; $display("FAIL duty_period got %0d want 10", r2 - r); end
      n_cmp++; if (run_len(r2, 1'b1) !== 7) begin n_bad++; $display("FAIL duty_next_high got %0d want 7", run_len(r2, 1'b1)); end
    end
  endtask

  task automatic test_center();
    int m, r1, r2;
    wb_write(32'h10, 32'h0, 4'hF);
    wb_write(32'h00, 32'h1, 4'hF);
    wb_write(32'h14, 32'd4, 4'hF);
    wb_write(32'h18, 32'd2, 4'hF);
    wb_write(32'h10, 32'h5, 4'hF);
    wait_clk(10);
    m = hist_n;
    wait_clk(50);
    r1 = find_rise(m);
    r2 = find_rise(r1 + 1);
    // Triangle 0,1,2,3,4,3,2,1 at two clocks per state; cnt<2 holds for states 1,0,1.
    n_cmp++; if (r2 - r1 !== 16) begin n_bad++; $display("FAIL ctr_period got %0d want 16", r2 - r1); end
    n_cmp++; if (run_len(r1, 1'b1) !== 6) begin n_bad++; $display("FAIL ctr_high got %0d want 6", run_len(r1, 1'b1)); end
    n_cmp++; if (run_len(r1 + 6, 1'b0) !== 10) begin n_bad++; $display("FAIL ctr_low got %0d want 10", run_len(r1 + 6, 1'b0)); end
  endtask

  task automatic test_boundaries();
    int m;
    logic [31:0] rd;
    int nc;
    wb_write(32'h10, 32'h0, 4'hF);
    wb_write(32'h00, 32'h0, 4'hF);
    wb_write(32'h14, 32'd9, 4'hF);
    wb_write(32'h18, 32'd0, 4'hF);
    wb_write(32'h10, 32'h1, 4'hF);
    wait_clk(25);
    m = hist_n;
    wait_clk(22);
    n_cmp++; if (count_hi(m, 20) !== 0) begin n_bad++; $display("FAIL duty0_highs got %0d want 0", count_hi(m, 20)); end
    wb_write(32'h18, 32'd10, 4'hF);
    wait_clk(25);
    m = hist_n;
    wait_clk(22);
    n_cmp++; if (count_hi(m, 20) !== 20) begin n_bad++; $display("FAIL dutymax_highs got %0d want 20", count_hi(m, 20)); end
    wb_write(32'h10, 32'h2, 4'hF);
    wait_clk(3);
    @(negedge clk);
    n_cmp++; if (pwmo[0] !== 1'b1) begin n_bad++; $display("FAIL pol_idle got %b want 1", pwmo[0]); end
    n_cmp++; if (pwmo[NUM_CH-1:1] !== '0) begin n_bad++; $display("FAIL other_ch got %h want 0", pwmo[NUM_CH-1:1]); end
    wb_read(32'h1C, rd, nc);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL dis_cnt got %h want 0", rd); end
    wb_write(32'h04, 32'hFF, 4'hF);
    wb_read(32'h04, rd, nc);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL gstat_w1c got %h want 0", rd); end
  endtask

  task automatic test_bus();
    logic [31:0] rd;
    int nc;
    wb_write(32'h24, 32'h1234_5678, 4'hF);
    wb_read(32'h24, rd, nc);
    n_cmp++; if (rd !== 32'h0000_5678) begin n_bad++; $display("FAIL period_trunc got %h want 00005678", rd); end
    wb_write(32'h24, 32'hAAAA_AA9C, 4'h1);
    wb_read(32'h24, rd, nc);
    n_cmp++; if (rd !== 32'h0000_569C) begin n_bad++; $display("FAIL byte_write got %h want 0000569c", rd); end
    wb_write(32'h28, 32'h42, 4'hF);
    wb_read(32'h3F0, rd, nc);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL unmapped_rd got %h want 0", rd); end
    n_cmp++; if (nc !== 2) begin n_bad++; $display("FAIL unmapped_lat got %0d want 2", nc); end
    wb_write(32'h08, 32'hFFFF_FFFF, 4'hF);
    wb_read(32'h08, rd, nc);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL hole_rd got %h want 0", rd); end
    wb_write(32'h00, 32'hFFFF_FFFF, 4'hF);
    wb_read(32'h00, rd, nc);
    n_cmp++; if (rd !== 32'h0000_FFFF) begin n_bad++; $display("FAIL gctrl_trunc got %h want 0000ffff", rd); end
    wb_write(32'h00, 32'h0, 4'hF);
    wb_write(32'h84, 32'hBEEF, 4'hF);
    wb_read(32'h84, rd, nc);
    n_cmp++; if (rd !== 32'h0000_BEEF) begin n_bad++; $display("FAIL last_ch got %h want 0000beef", rd); end
    wb_write(32'h94, 32'h1234, 4'hF);
    wb_read(32'h94, rd, nc);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL beyond_ch got %h want 0", rd); end
  endtask

  task automatic test_back_to_back();
    int acks = 0;
    logic [31:0] d1 = '0;
    logic [31:0] d2 = '0;
    @(posedge clk); #1;
    bus.wb_stb_i = 1'b1; bus.wb_cyc_i = 1'b1; bus.wb_we_i = 1'b0;
    bus.wb_adr_i = 32'h24; bus.wb_sel_i = 4'hF;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.wb_ack_o === 1'b1) begin
        acks++;
        if (acks == 1) d1 = bus.wb_dat_o; else d2 = bus.wb_dat_o;
      end
      @(posedge clk); #1;
      if (k == 1) bus.wb_adr_i = 32'h28;
    end
    bus.wb_stb_i = 1'b0; bus.wb_cyc_i = 1'b0;
    n_cmp++; if (acks !== 2) begin n_bad++; $display("FAIL b2b_acks got %0d want 2", acks); end
    n_cmp++; if (d1 !== 32'h0000_569C) begin n_bad++; $display("FAIL b2b_first got %h want 0000569c", d1); end
    n_cmp++; if (d2 !== 32'h0000_0042) begin n_bad++; $display("FAIL b2b_second got %h want 00000042", d2); end
  endtask

  initial begin
    reset_n      = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_cyc_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    bus.wb_adr_i = '0;
    bus.wb_sel_i = '0;
    bus.wb_dat_i = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_edge();
    test_duty_change();
    test_center();
    test_boundaries();
    test_bus();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
